fifo_rr_drain_arbiter: RTL and testbench
========================================

Name: fifo_rr_drain_arbiter

Overview:
- Shares one downstream valid/ready stream among NUM_CH upstream synchronous FIFOs.
- Each FIFO has registered dout with 1-cycle read latency, an empty flag and an rd_en input.
- Grants channels round-robin and drains up to BURST_MAX words per grant.
- Tags each output word with its source channel and end-of-burst.
- Sits between the per-channel FIFO bank and the single shared egress.

Parameters:
- NUM_CH, 4, number of upstream FIFOs (2..16).
- DATA_WIDTH, 8, word width; must match the FIFOs.
- BURST_MAX, 4, maximum words drained per grant (>=1).
- CH_W, $clog2(NUM_CH), localparam, channel index width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- ch_en  in  NUM_CH  per-channel arbitration enable.
- fifo_empty  in  NUM_CH  empty flags from the FIFOs.
- fifo_dout  in  NUM_CH*DATA_WIDTH  packed FIFO read data; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- fifo_rd_en  out  NUM_CH  one-hot-or-zero read strobe to the FIFOs.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  output word, registered.
- m_ch  out  CH_W  source channel of m_data.
- m_last  out  1  last word of the current burst.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, last_grant=NUM_CH-1, beat_cnt=0.
- All outputs reset to 0: m_valid, m_data, m_ch, m_last, busy, fifo_rd_en.
- FSM states: IDLE, WAIT, SEND.
- IDLE:
  - req = ch_en & ~fifo_empty.
  - Pick the first set bit of req searching from last_grant+1 upward, with wrap.
  - If a channel is found: assert fifo_rd_en[g] combinationally this cycle, latch grant=g, beat_cnt=0, go WAIT.
  - Otherwise stay in IDLE.
- WAIT (fifo_dout[grant] now holds the word):
  - m_data <= fifo_dout[grant], m_ch <= grant.
  - m_last <= (beat_cnt==BURST_MAX-1) || fifo_empty[grant].
  - m_valid <= 1, go SEND.
  - m_last is fixed at capture time. Words arriving after the empty sample do not extend the burst.
- SEND:
  - Hold m_valid, m_data, m_ch and m_last stable until m_ready. This is the AXI-style rule: valid never drops without ready.
  - On m_ready with m_last=0: assert fifo_rd_en[grant] combinationally, beat_cnt++, m_valid <= 0, go WAIT.
  - On m_ready with m_last=1: m_valid <= 0, last_grant <= grant, go IDLE.
- fifo_rd_en is asserted only when the addressed fifo_empty bit is 0. Never more than one bit is set. The block never reads an empty FIFO.
- Latency: rd_en in cycle T; m_valid first high at T+2.
- Steady-state throughput: 1 word per 2 cycles within a burst, plus 1 IDLE cycle per burst.
- ch_en is sampled only in IDLE. Deasserting it mid-burst does not abort the burst.
- Fairness: after a grant to channel g, every other requesting channel is granted before g again. With all channels busy, starvation is bounded by (NUM_CH-1) bursts.
- Single requester: re-granted after one IDLE cycle.
- beat_cnt width is $clog2(BURST_MAX)+1. No wrap is possible because the burst ends at BURST_MAX-1.
- Reset mid-burst: outputs clear immediately. Any word captured but not accepted is dropped (upstream count was already decremented; documented loss).
- busy = (state != IDLE).

Decomposition:
- Package fifo_arb_pkg: state enum (IDLE, WAIT, SEND) as a 2-bit typedef, and function next_rr_idx.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_CH], last[CH_W].
  - Outputs: found, idx[CH_W].
  - Implemented as a double-width request rotate followed by a priority encode.
- Top holds the FSM, capture registers and the rd_en decode.

Test Plan:
- Reset with all FIFOs holding data -> all outputs 0. The first grant after release goes to ch0 (last_grant=3). m_valid rises 2 cycles after fifo_rd_en[0].
- NUM_CH=4, BURST_MAX=4, ch0 preloaded with 10 words 0x00..0x09, m_ready=1 -> first burst 0x00..0x03 on ch0, m_last on 0x03. ch0 is re-granted after one IDLE cycle. Bursts are 4,4,2 words, with m_last on 0x03, 0x07 and 0x09.
- All 4 channels hold 8 words, m_ready=1 -> grant order 0,1,2,3,0,1,2,3. Each burst is 4 words, m_ch matches the grant, and no fifo_rd_en is ever issued on an empty channel.
- ch2 holds a single word 0xA5 -> one beat with m_ch=2 and m_last=1. A word pushed into ch2 during SEND is not appended; it is served in a later grant.
- Backpressure: m_ready held low 5 cycles in SEND -> m_valid, m_data, m_ch and m_last stable across all 5. No fifo_rd_en during stall. Draining resumes on the cycle m_ready rises.
- ch_en=4'b1011 with all channels non-empty -> ch2 is never granted. ch_en dropped to 0 mid-burst on ch1 -> that burst completes, then the arbiter idles. rst_n pulsed low mid-SEND -> m_valid and fifo_rd_en go to 0 asynchronously.

Source files
------------

// File: rtl/fifo_rr_drain_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO drain arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } arb_state_t;

    // First index to consider after a grant to 'last'; wraps at num_ch.
    function automatic int unsigned next_rr_idx(input int unsigned last,
                                                input int unsigned num_ch);
        return (last + 1) % num_ch;
    endfunction

endpackage

// File: rtl/fifo_rr_drain_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', with wrap.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic              found,
    output logic [CH_W-1:0]   idx
);

    logic [2*NUM_CH-1:0] req_dbl;
    logic [2*NUM_CH-1:0] rot_dbl;
    logic [NUM_CH-1:0]   rot;
    int unsigned         start;
    int unsigned         off;

    // Rotating the doubled vector puts the search start at bit 0, so a plain
    // lowest-set-bit encode yields the round-robin winner as an offset.
    always_comb begin
        start   = next_rr_idx(32'(last), NUM_CH);
        req_dbl = {req, req};
        rot_dbl = req_dbl >> start;
        rot     = rot_dbl[NUM_CH-1:0];
        found   = 1'b0;
        off     = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rot[i] && !found) begin
                found = 1'b1;
                off   = i;
            end
        end
        idx = CH_W'((start + off) % NUM_CH);
    end

endmodule

// File: rtl/fifo_rr_drain_arbiter.sv
// Drains NUM_CH upstream FIFOs round-robin, up to BURST_MAX words per grant,
// onto one valid/ready stream tagged with source channel and end-of-burst.
module fifo_rr_drain_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int BURST_MAX  = 4,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [NUM_CH-1:0]            fifo_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_dout,
    output logic [NUM_CH-1:0]            fifo_rd_en,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [CH_W-1:0]              m_ch,
    output logic                         m_last,
    output logic                         busy
);

    localparam int BC_W = $clog2(BURST_MAX) + 1;

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [CH_W-1:0]       grant;
    logic [CH_W-1:0]       last_grant;
    logic [CH_W-1:0]       pick_idx;
    logic                  pick_found;
    logic [BC_W-1:0]       beat_cnt;
    logic [NUM_CH-1:0]     req;
    logic [NUM_CH-1:0]     rd_sel;
    logic [DATA_WIDTH-1:0] grant_word;

    assign req        = ch_en & ~fifo_empty;
    assign grant_word = fifo_dout[int'(grant)*DATA_WIDTH +: DATA_WIDTH];

    rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req   (req),
        .last  (last_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = WAIT;
            WAIT:    state_nxt = SEND;
            SEND:    if (m_ready) state_nxt = m_last ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    // Read strobe is gated by rst_n so it drops the moment reset asserts.
    always_comb begin
        rd_sel = '0;
        case (state)
            IDLE: if (pick_found) rd_sel[pick_idx] = 1'b1;
            SEND: if (m_ready && !m_last && !fifo_empty[grant]) rd_sel[grant] = 1'b1;
            default: rd_sel = '0;
        endcase
        fifo_rd_en = rd_sel & {NUM_CH{rst_n}};
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            beat_cnt   <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_ch       <= '0;
            m_last     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_found) begin
                    grant    <= pick_idx;
                    beat_cnt <= '0;
                end
                // End-of-burst is decided here; later pushes cannot extend it.
                WAIT: begin
                    m_data  <= grant_word;
                    m_ch    <= grant;
                    m_last  <= (beat_cnt == BC_W'(BURST_MAX - 1)) || fifo_empty[grant];
                    m_valid <= 1'b1;
                end
                SEND: if (m_ready) begin
                    m_valid <= 1'b0;
                    if (m_last) last_grant <= grant;
                    else        beat_cnt   <= beat_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Self-checking bench: behavioural FIFO bank, first-grant vector table and
// a scoreboard of expected {channel, word, last} beats.
module tb_fifo_rr_drain_arbiter;

    localparam int NUM_CH = 4;
    localparam int DW     = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_CH-1:0]    ch_en = '0;
    logic [NUM_CH-1:0]    fifo_empty = '1;
    logic [NUM_CH*DW-1:0] fifo_dout = '0;
    logic [NUM_CH-1:0]    fifo_rd_en;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic [DW-1:0]        m_data;
    logic [1:0]           m_ch;
    logic                 m_last;
    logic                 busy;

    typedef struct {
        logic [1:0]    ch;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [NUM_CH-1:0] en;
        logic [NUM_CH-1:0] nonempty;
        logic [NUM_CH-1:0] exp_rd;
    } grant_vec_t;

    beat_t         exp_q[$];
    logic [DW-1:0] fq[NUM_CH][$];
    logic [NUM_CH-1:0] rd_snap;
    grant_vec_t    vecs[6];
    int            errors = 0;
    int            checks = 0;
    int            n;
    logic [11:0]   snap;

    fifo_rr_drain_arbiter #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .BURST_MAX  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_en      (ch_en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_ch       (m_ch),
        .m_last     (m_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int c = 0; c < NUM_CH; c++) fifo_empty[c] = (fq[c].size() == 0);
    endtask

    task automatic push_word(input int c, input logic [DW-1:0] d);
        fq[c].push_back(d);
        refresh();
    endtask

    task automatic expect_beat(input logic [1:0] c, input logic [DW-1:0] d, input logic l);
        beat_t e;
        e.ch = c; e.data = d; e.last = l;
        exp_q.push_back(e);
    endtask

    // Called at the falling edge: compare any accepted beat, check the strobe.
    task automatic sb_observe();
        beat_t e;
        if (fifo_rd_en != '0)
            check("rd_onehot_nonempty",
                  32'($onehot(fifo_rd_en) && ((fifo_rd_en & fifo_empty) == '0)), 32'd1);
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_beat", {21'd0, m_ch, m_data, m_last}, 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                check("sb_beat", {21'd0, m_ch, m_data, m_last}, {21'd0, e.ch, e.data, e.last});
            end
        end
    endtask

    // Rising edge plus the FIFO model's registered read response.
    task automatic edge_step();
        rd_snap = fifo_rd_en;
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_snap[c]) begin
                if (fq[c].size() == 0) check("read_of_empty_fifo", c, 32'hffff_ffff);
                else fifo_dout[c*DW +: DW] = fq[c].pop_front();
            end
        end
        refresh();
    endtask

    task automatic cycle();
        @(negedge clk);
        sb_observe();
        edge_step();
    endtask

    task automatic drain(input int max_cycles, output int used);
        used = 0;
        while (exp_q.size() > 0 && used < max_cycles) begin
            cycle();
            used++;
        end
        check("drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        m_ready = 1'b0;
        ch_en   = '0;
        for (int c = 0; c < NUM_CH; c++) fq[c].delete();
        fifo_dout = '0;
        exp_q.delete();
        refresh();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // First grant after reset (last_grant = 3): lowest requesting channel.
        vecs[0] = '{en: 4'b1111, nonempty: 4'b1111, exp_rd: 4'b0001};
        vecs[1] = '{en: 4'b1111, nonempty: 4'b1110, exp_rd: 4'b0010};
        vecs[2] = '{en: 4'b1011, nonempty: 4'b1100, exp_rd: 4'b1000};
        vecs[3] = '{en: 4'b0000, nonempty: 4'b1111, exp_rd: 4'b0000};
        vecs[4] = '{en: 4'b1111, nonempty: 4'b0000, exp_rd: 4'b0000};
        vecs[5] = '{en: 4'b0100, nonempty: 4'b0110, exp_rd: 4'b0100};

        // Reset with every FIFO holding data: all outputs low.
        for (int c = 0; c < NUM_CH; c++) push_word(c, 8'h40 + 8'(c));
        ch_en = 4'b1111;
        @(negedge clk);
        check("reset_outputs", {fifo_rd_en, m_valid, m_data, m_ch, m_last, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_rd_ch0", fifo_rd_en, 4'b0001);
        sb_observe();
        edge_step();
        @(negedge clk);
        check("lat_t1_valid_busy", {m_valid, busy}, 2'b01);
        edge_step();
        @(negedge clk);
        check("lat_t2_beat", {m_valid, m_ch, m_data}, {1'b1, 2'd0, 8'h40});
        edge_step();

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int c = 0; c < NUM_CH; c++)
                if (vecs[v].nonempty[c]) push_word(c, 8'(c));
            ch_en = vecs[v].en;
            @(negedge clk);
            check($sformatf("vec%0d_rd_en", v), fifo_rd_en, vecs[v].exp_rd);
            check($sformatf("vec%0d_idle", v), {busy, m_valid}, 2'b00);
        end

        // Single channel, 10 words: bursts 4,4,2 with one IDLE cycle between.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push_word(0, 8'(i));
            expect_beat(2'd0, 8'(i), (i == 3) || (i == 7) || (i == 9));
        end
        ch_en = 4'b0001; m_ready = 1'b1;
        drain(100, n);
        check("ch0_burst_cycles", n, 23);

        // All channels, 8 words each: grant order 0,1,2,3,0,1,2,3.
        do_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < 8; i++) push_word(c, 8'(c*16 + i));
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NUM_CH; c++)
                for (int i = 0; i < 4; i++)
                    expect_beat(2'(c), 8'(c*16 + r*4 + i), i == 3);
        ch_en = 4'b1111; m_ready = 1'b1;
        drain(300, n);

        // Single word on ch2; a word pushed during SEND forms a later burst.
        do_reset();
        push_word(2, 8'hA5);
        expect_beat(2'd2, 8'hA5, 1'b1);
        ch_en = 4'b1111;
        cycle(); cycle();
        push_word(2, 8'h5A);
        expect_beat(2'd2, 8'h5A, 1'b1);
        m_ready = 1'b1;
        drain(20, n);

        // Backpressure: 5 stalled cycles in SEND, then resume.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_word(1, 8'h20 + 8'(i));
            expect_beat(2'd1, 8'h20 + 8'(i), i == 3);
        end
        ch_en = 4'b0010;
        n = 0;
        while (!m_valid && n < 10) begin cycle(); n++; end
        check("bp_valid_up", m_valid, 1'b1);
        snap = {m_valid, m_ch, m_data, m_last};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_stable", {m_valid, m_ch, m_data, m_last}, snap);
            check("bp_no_rd", fifo_rd_en, 4'b0000);
            sb_observe();
            edge_step();
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_rd", fifo_rd_en, 4'b0010);
        sb_observe();
        edge_step();
        drain(20, n);

        // ch2 disabled: never granted while others are served.
        do_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < 4; i++) push_word(c, 8'(c*16 + i));
        for (int c = 0; c < NUM_CH; c++)
            if (c != 2)
                for (int i = 0; i < 4; i++) expect_beat(2'(c), 8'(c*16 + i), i == 3);
        ch_en = 4'b1011; m_ready = 1'b1;
        drain(100, n);
        for (int k = 0; k < 4; k++) cycle();
        check("ch2_untouched", fq[2].size(), 4);
        check("ch2_idle_after", busy, 1'b0);

        // ch_en dropped mid-burst: burst completes, then idle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_word(1, 8'h60 + 8'(i));
            push_word(0, 8'h70 + 8'(i));
            expect_beat(2'd1, 8'h60 + 8'(i), i == 3);
        end
        ch_en = 4'b0010;
        cycle(); cycle();
        ch_en = 4'b0000; m_ready = 1'b1;
        drain(20, n);
        for (int k = 0; k < 3; k++) cycle();
        check("en_drop_idle", busy, 1'b0);
        check("en_drop_ch0_kept", fq[0].size(), 4);

        // Async reset mid-SEND.
        do_reset();
        for (int i = 0; i < 4; i++) push_word(3, 8'h80 + 8'(i));
        ch_en = 4'b1000;
        cycle(); cycle();
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        check("pre_rst_send", {m_valid, fifo_rd_en}, {1'b1, 4'b1000});
        rst_n = 1'b0;
        #1;
        check("async_rst_clear", {m_valid, fifo_rd_en, busy, m_data}, 32'd0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
